data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. It accepts ram_addr, ram_sel, ram_rw, ram_data_in and ram_extend_type from the MEM stage and returns ram_data_out in the same cycle.
- Adds a post-reset clear engine, byte-lane write/read alignment, a slow scan read port for board display, and a write counter.
- Sits between the CPU core and the board top level, in place of a bare RAM.

Parameters:
- ADDR_BITS, 12, byte-address width. Word index is ADDR_BITS-2 bits; DEPTH = 2^(ADDR_BITS-2) words (1024 at default).
- SCAN_DIV, 16, clk cycles per scan-port step; must be >= 1.
- GUARD_WORDS, 4, number of protected low words; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ram_addr  input  ADDR_BITS-2  word index.
- ram_data_in  input  32  store data, right-aligned.
- ram_sel  input  4  byte-lane select; bit i = bits 8i+7:8i.
- ram_rw  input  1  1 = write this cycle.
- ram_extend_type  input  1  read extension: 0 = zero, 1 = sign.
- ram_data_out  output  32  combinational read data, right-aligned.
- mem_ready  output  1  1 once the clear sequence is complete.
- scan_addr  output  ADDR_BITS-2  word index currently shown on the scan port.
- scan_data  output  32  registered word at scan_addr.
- write_count  output  32  number of accepted writes, saturating.

Behaviour:
- Reset (rst=0, async): state=CLEAR, clear pointer=0, mem_ready=0, scan_addr=0, scan_data=0, write_count=0, scan divider=0. Memory array contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes 32'h0 to word[pointer], then pointer+1.
  - After writing word DEPTH-1, goes to READY; mem_ready=1 from the next cycle.
  - Total DEPTH cycles after rst rises.
  - CPU writes are ignored, write_count does not change, ram_data_out=0.
- FSM READY: stays in READY until reset. Reset asserted mid-CLEAR or mid-READY restarts CLEAR from 0.
- Legal ram_sel values: 1111 (word), 0011 and 1100 (halfword), 0001/0010/0100/1000 (byte). Lowest selected lane = k.
- Write:
  - Occurs on the rising edge when mem_ready=1, ram_rw=1 and ram_sel!=0.
  - Source byte j of ram_data_in goes to lane k+j, for every selected lane.
  - Unselected lanes are unchanged.
  - write_count increments by 1 per accepted write and saturates at 32'hFFFFFFFF.
  - ram_sel=0000 with ram_rw=1: no write, no count.
- Read (combinational, every cycle):
  - Selected lanes are shifted down by k bytes.
  - Upper bits are filled with zero (extend_type=0) or with copies of the MSB of the highest selected byte (extend_type=1).
  - ram_sel=0000 gives 0.
  - Illegal non-contiguous sel: write uses raw lanes unshifted; read returns the raw full word.
- Write and read of the same word in the same cycle: ram_data_out shows the pre-write contents; new data is visible the next cycle.
- Scan port:
  - Active only in READY.
  - Divider counts 0..SCAN_DIV-1. On terminal count, scan_addr increments, wrapping DEPTH-1 -> 0.
  - scan_data is registered every cycle from word[scan_addr], so it lags an address change by 1 cycle.
  - A scan read never blocks or alters CPU access.

Optional Feature:
- DMEM_WRITE_GUARD_EN defined:
  - Adds output port guard_hit (1 bit, reset 0, sticky until reset).
  - A READY write with ram_addr < GUARD_WORDS is dropped: memory unchanged, write_count unchanged, guard_hit set to 1.
  - Reads of guarded words are unaffected.
  - The CLEAR sequence still clears guarded words.
- Undefined: guard_hit port absent; all READY writes are accepted; GUARD_WORDS unused.

Test Plan:
- Reset, then release rst -> mem_ready=0 for exactly 1024 cycles, then 1; read any address = 32'h0; write_count=0.
- Word write addr 5, data 32'hDEADBEEF, sel 1111 -> next cycle read sel 1111 = 32'hDEADBEEF; write_count=1. Same-cycle read returned the old value 0.
- Byte store 32'h000000A5 to addr 7, sel 0100 -> read sel 1111 = 32'h00A50000. Read sel 0100 with ext 0 = 32'h000000A5; with ext 1 = 32'hFFFFFFA5.
- Halfword store 32'h00008001 to addr 9, sel 1100 -> read sel 1111 = 32'h80010000. Read sel 1100 with ext 1 = 32'hFFFF8001. Write with sel 0000 -> no change, count unchanged.
- Write during CLEAR at cycle 10, then reset asserted at cycle 500 of CLEAR -> write ignored; CLEAR restarts; mem_ready rises 1024 cycles after rst rises.
- SCAN_DIV=2, word 0 = 32'h12345678 -> scan_addr steps every 2 cycles, scan_data=32'h12345678 one cycle after scan_addr=0, wraps 1023 -> 0. With DMEM_WRITE_GUARD_EN, a write to addr 2 -> dropped, guard_hit=1.

Source files
------------

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of the CPU data-memory interface. It replaces a bare RAM
// between the CPU core and the board top level.
//   * After reset a clear engine zeroes every word, one per cycle. mem_ready
//     goes high once the last word has been cleared.
//   * CPU reads are combinational. Selected byte lanes are shifted down to
//     bit 0 and then zero- or sign-extended. CPU writes shift right-aligned
//     store data up into the selected lanes.
//   * A slow scan port walks every word for board display.
//   * A saturating counter counts accepted writes.
//
// Optional feature (macro DMEM_WRITE_GUARD_EN):
//   Adds the sticky guard_hit output. In READY, writes to word indices below
//   GUARD_WORDS are dropped and set guard_hit. The clear engine still clears
//   the guarded words.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   ram_addr         word index
//   ram_data_in      store data, right-aligned
//   ram_sel          byte-lane select; bit i covers bits 8i+7:8i
//   ram_rw           1 = write this cycle
//   ram_extend_type  read extension: 0 = zero, 1 = sign
//   ram_data_out     combinational read data, right-aligned
//   mem_ready        1 once the clear sequence has finished
//   scan_addr        word index currently shown on the scan port
//   scan_data        registered word at scan_addr (lags scan_addr by 1 cycle)
//   guard_hit        sticky dropped-write flag (DMEM_WRITE_GUARD_EN only)
//   write_count      accepted writes, saturating at 32'hFFFFFFFF
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int SCAN_DIV    = 16,
  parameter int GUARD_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-3:0] ram_addr,
  input  logic [31:0]          ram_data_in,
  input  logic [3:0]           ram_sel,
  input  logic                 ram_rw,
  input  logic                 ram_extend_type,
  output logic [31:0]          ram_data_out,
  output logic                 mem_ready,
  output logic [ADDR_BITS-3:0] scan_addr,
  output logic [31:0]          scan_data,
`ifdef DMEM_WRITE_GUARD_EN
  output logic                 guard_hit,
`endif
  output logic [31:0]          write_count
);

  localparam int AW    = ADDR_BITS - 2;
  localparam int DEPTH = 1 << AW;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

`ifdef DMEM_WRITE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  logic [31:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            mem_ready_q, mem_ready_d;
  logic [AW-1:0]   scan_addr_q, scan_addr_d;
  logic [31:0]     scan_data_q, scan_data_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]     wc_q, wc_d;

  // Lane decode
  logic       sel_legal;
  logic [1:0] lsb_lane;
  size_e      size;

  logic        wr_req;
  logic        guard_blk;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic        rd_sign;
  logic [31:0] rd_data;

  // NOTE: every variable assigned in an always_comb gets a default value
  // first. A path that leaves a variable unassigned infers a latch.
  always_comb begin
    sel_legal = 1'b1;
    lsb_lane  = 2'd0;
    size      = SZ_WORD;
    case (ram_sel)
      4'b1111: ;
      4'b0011: size = SZ_HALF;
      4'b1100: begin size = SZ_HALF; lsb_lane = 2'd2; end
      4'b0001: size = SZ_BYTE;
      4'b0010: begin size = SZ_BYTE; lsb_lane = 2'd1; end
      4'b0100: begin size = SZ_BYTE; lsb_lane = 2'd2; end
      4'b1000: begin size = SZ_BYTE; lsb_lane = 2'd3; end
      default: sel_legal = 1'b0;  // 0000 or non-contiguous: raw lanes
    endcase
  end

  // Write path. Non-contiguous selects store the raw lanes unshifted.
  always_comb begin
    wr_req    = mem_ready_q && ram_rw && (ram_sel != 4'b0000);
    guard_blk = GUARD_EN && (ram_addr < AW'(GUARD_WORDS));
    wr_en     = wr_req && !guard_blk;
    wr_data   = sel_legal ? (ram_data_in << {lsb_lane, 3'b000}) : ram_data_in;
  end

  // Read path. The array is read before the clock edge, so a same-cycle
  // write to the same word shows the old contents until the next cycle.
  always_comb begin
    rd_word  = mem[ram_addr];
    rd_shift = rd_word >> {lsb_lane, 3'b000};
    rd_sign  = 1'b0;
    rd_data  = '0;
    if (mem_ready_q && (ram_sel != 4'b0000)) begin
      if (!sel_legal) begin
        rd_data = rd_word;
      end else begin
        case (size)
          SZ_BYTE: begin
            rd_sign = ram_extend_type & rd_shift[7];
            rd_data = {{24{rd_sign}}, rd_shift[7:0]};
          end
          SZ_HALF: begin
            rd_sign = ram_extend_type & rd_shift[15];
            rd_data = {{16{rd_sign}}, rd_shift[15:0]};
          end
          default: rd_data = rd_shift;
        endcase
      end
    end
  end

  // Control and scan next-state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mem_ready_d = mem_ready_q;
    scan_addr_d = scan_addr_q;
    scan_data_d = scan_data_q;
    div_d       = div_q;
    wc_d        = wc_q;

    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == '1) begin
          state_d     = ST_READY;
          mem_ready_d = 1'b1;
        end
      end
      ST_READY: begin
        scan_data_d = mem[scan_addr_q];
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d       = '0;
          scan_addr_d = scan_addr_q + AW'(1);  // wraps DEPTH-1 -> 0
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (wr_en && (wc_q != 32'hFFFF_FFFF)) begin
          wc_d = wc_q + 32'd1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values present before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      mem_ready_q <= 1'b0;
      scan_addr_q <= '0;
      scan_data_q <= '0;
      div_q       <= '0;
      wc_q        <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mem_ready_q <= mem_ready_d;
      scan_addr_q <= scan_addr_d;
      scan_data_q <= scan_data_d;
      div_q       <= div_d;
      wc_q        <= wc_d;
    end
  end

  // NOTE: the array has no reset branch, so it maps onto RAM. The clear
  // engine zeroes it word by word after reset instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_sel[i]) begin
          mem[ram_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_WRITE_GUARD_EN
  logic guard_hit_q, guard_hit_d;

  always_comb begin
    guard_hit_d = guard_hit_q | (wr_req & guard_blk);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) guard_hit_q <= 1'b0;
    else      guard_hit_q <= guard_hit_d;
  end

  assign guard_hit = guard_hit_q;
`endif

  assign ram_data_out = rd_data;
  assign mem_ready    = mem_ready_q;
  assign scan_addr    = scan_addr_q;
  assign scan_data    = scan_data_q;
  assign write_count  = wc_q;

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder (ADDR_BITS=12, SCAN_DIV=2).
// Expected values go onto a scoreboard queue when the stimulus is driven.
// They are popped and compared when the DUT output is sampled, either half a
// cycle after inputs change or one cycle later for write read-backs.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int AW = 10;
`ifdef DMEM_WRITE_GUARD_EN
  localparam logic [AW-1:0] SCAN_WORD = 10'd4;
`else
  localparam logic [AW-1:0] SCAN_WORD = 10'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data_in;
  logic [3:0]    ram_sel;
  logic          ram_rw;
  logic          ram_extend_type;
  logic [31:0]   ram_data_out;
  logic          mem_ready;
  logic [AW-1:0] scan_addr;
  logic [31:0]   scan_data;
  logic [31:0]   write_count;
`ifdef DMEM_WRITE_GUARD_EN
  logic          guard_hit;
`endif

  int tests_run  = 0;
  int fail_count = 0;
  int exp_count  = 0;
  int n;
  int m;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_BITS  (12),
    .SCAN_DIV   (2),
    .GUARD_WORDS(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_addr       (ram_addr),
    .ram_data_in    (ram_data_in),
    .ram_sel        (ram_sel),
    .ram_rw         (ram_rw),
    .ram_extend_type(ram_extend_type),
    .ram_data_out   (ram_data_out),
    .mem_ready      (mem_ready),
    .scan_addr      (scan_addr),
    .scan_data      (scan_data),
`ifdef DMEM_WRITE_GUARD_EN
    .guard_hit      (guard_hit),
`endif
    .write_count    (write_count)
  );

  task automatic expect_val(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      fail_count++;
      $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fail_count++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  // Apply one CPU access just after the falling edge. Combinational outputs
  // are sampled when the task returns.
  task automatic drive(input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic rw, input logic ext);
    @(negedge clk);
    ram_addr        = a;
    ram_data_in     = d;
    ram_sel         = s;
    ram_rw          = rw;
    ram_extend_type = ext;
    #1;
  endtask

  // Count rising edges from here until mem_ready is seen high (bounded).
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (cycles < 2000) begin
      @(posedge clk);
      cycles++;
      #1;
      if (mem_ready) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ram_addr = '0; ram_data_in = '0; ram_sel = '0; ram_rw = 1'b0;
    ram_extend_type = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    #1;
    expect_val("rst_mem_ready", 32'd0);   check(32'(mem_ready));
    expect_val("rst_write_count", 32'd0); check(write_count);
    expect_val("rst_scan_addr", 32'd0);   check(32'(scan_addr));
    expect_val("rst_scan_data", 32'd0);   check(scan_data);

    // ---- CLEAR: write attempt at cycle 10, reset at cycle 500 ----
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (n < 500) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 10) begin
        ram_addr = 10'd3; ram_data_in = 32'hAAAA_5555; ram_sel = 4'b1111;
        ram_rw = 1'b1;
        expect_val("clear_rd_zero", 32'd0); check(ram_data_out);
      end
      if (n == 11) ram_rw = 1'b0;
    end
    expect_val("clear_mid_not_ready", 32'd0); check(32'(mem_ready));
    rst = 1'b0;
    #1;
    expect_val("mid_clear_rst_ready", 32'd0); check(32'(mem_ready));
    @(negedge clk);
    rst = 1'b1;
    wait_ready(n);
    expect_val("clear_cycles", 32'd1024);    check(32'(n));
    expect_val("clear_write_ignored", 32'd0); check(write_count);
    drive(10'd3, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("post_clear_rd", 32'd0);      check(ram_data_out);

    // ---- word write, same-cycle read shows old value ----
    drive(10'd5, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0);
    expect_val("same_cycle_old", 32'd0);
    expect_val("word_rd", 32'hDEAD_BEEF);
    exp_count++;
    check(ram_data_out);
    drive(10'd5, 32'd0, 4'b1111, 1'b0, 1'b0);
    check(ram_data_out);
    expect_val("count_word", 32'(exp_count)); check(write_count);

    // ---- byte store to lane 2 ----
    drive(10'd7, 32'h0000_00A5, 4'b0100, 1'b1, 1'b0);
    exp_count++;
    drive(10'd7, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("byte_word_rd", 32'h00A5_0000); check(ram_data_out);
    drive(10'd7, 32'd0, 4'b0100, 1'b0, 1'b0);
    expect_val("byte_rd_zext", 32'h0000_00A5); check(ram_data_out);
    drive(10'd7, 32'd0, 4'b0100, 1'b0, 1'b1);
    expect_val("byte_rd_sext", 32'hFFFF_FFA5); check(ram_data_out);

    // ---- halfword store to upper half ----
    drive(10'd9, 32'h0000_8001, 4'b1100, 1'b1, 1'b0);
    exp_count++;
    drive(10'd9, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("half_word_rd", 32'h8001_0000); check(ram_data_out);
    drive(10'd9, 32'd0, 4'b1100, 1'b0, 1'b1);
    expect_val("half_rd_sext", 32'hFFFF_8001); check(ram_data_out);
    drive(10'd9, 32'd0, 4'b1100, 1'b0, 1'b0);
    expect_val("half_rd_zext", 32'h0000_8001); check(ram_data_out);

    // ---- sel 0000 write: no store, no count, read gives 0 ----
    drive(10'd9, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1);
    expect_val("sel0_rd", 32'd0); check(ram_data_out);
    drive(10'd9, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("sel0_nowrite", 32'h8001_0000); check(ram_data_out);
    expect_val("sel0_count", 32'(exp_count)); check(write_count);

    // ---- byte merge into lane 1 of an existing word ----
    drive(10'd5, 32'h0000_005A, 4'b0010, 1'b1, 1'b0);
    exp_count++;
    drive(10'd5, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("merge_word_rd", 32'hDEAD_5AEF); check(ram_data_out);
    drive(10'd5, 32'd0, 4'b0010, 1'b0, 1'b1);
    expect_val("lane1_sext_pos", 32'h0000_005A); check(ram_data_out);
    drive(10'd5, 32'd0, 4'b1000, 1'b0, 1'b1);
    expect_val("lane3_sext_neg", 32'hFFFF_FFDE); check(ram_data_out);
    drive(10'd5, 32'd0, 4'b0011, 1'b0, 1'b1);
    expect_val("lowhalf_sext_pos", 32'h0000_5AEF); check(ram_data_out);
    drive(10'd5, 32'd0, 4'b1100, 1'b0, 1'b0);
    expect_val("highhalf_zext", 32'h0000_DEAD); check(ram_data_out);

    // ---- non-contiguous select: raw lanes both ways ----
    drive(10'd11, 32'h1122_3344, 4'b0101, 1'b1, 1'b0);
    exp_count++;
    drive(10'd11, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("illegal_wr_raw", 32'h0022_0044); check(ram_data_out);
    drive(10'd5, 32'd0, 4'b0110, 1'b0, 1'b1);
    expect_val("illegal_rd_raw", 32'hDEAD_5AEF); check(ram_data_out);
    expect_val("count_after_illegal", 32'(exp_count)); check(write_count);

    // ---- write to low word 2 ----
`ifdef DMEM_WRITE_GUARD_EN
    drive(10'd2, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b0);
    expect_val("guard_before", 32'd0); check(32'(guard_hit));
    drive(10'd2, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("guard_dropped", 32'd0); check(ram_data_out);
    expect_val("guard_hit_set", 32'd1); check(32'(guard_hit));
    expect_val("guard_count", 32'(exp_count)); check(write_count);
`else
    drive(10'd2, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b0);
    exp_count++;
    drive(10'd2, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("low_word_wr", 32'hCAFE_F00D); check(ram_data_out);
    expect_val("low_word_count", 32'(exp_count)); check(write_count);
`endif

    // ---- scan port ----
    drive(SCAN_WORD, 32'h1234_5678, 4'b1111, 1'b1, 1'b0);
    exp_count++;
    drive(10'd0, 32'd0, 4'b0000, 1'b0, 1'b0);
    expect_val("scan_word_count", 32'(exp_count)); check(write_count);

    n = 0;
    while ((scan_addr != 10'h3FF) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    expect_val("scan_reach_top", 32'h3FF); check(32'(scan_addr));
    m = 0;
    while ((scan_addr == 10'h3FF) && (m < 10)) begin
      @(negedge clk);
      m++;
    end
    expect_val("scan_step_cycles", 32'd2); check(32'(m));
    expect_val("scan_wrap_zero", 32'd0);   check(32'(scan_addr));
    m = 0;
    while ((scan_addr != SCAN_WORD) && (m < 20)) begin
      @(negedge clk);
      m++;
    end
    @(negedge clk);
    expect_val("scan_data_lag", 32'h1234_5678); check(scan_data);

    // ---- reset during READY restarts the clear ----
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_val("ready_rst_ready", 32'd0); check(32'(mem_ready));
    expect_val("ready_rst_count", 32'd0); check(write_count);
    expect_val("ready_rst_scan", 32'd0);  check(32'(scan_addr));
`ifdef DMEM_WRITE_GUARD_EN
    expect_val("ready_rst_guard", 32'd0); check(32'(guard_hit));
`endif
    @(negedge clk);
    rst = 1'b1;
    wait_ready(n);
    expect_val("reclear_cycles", 32'd1024); check(32'(n));
    drive(10'd5, 32'd0, 4'b1111, 1'b0, 1'b0);
    expect_val("reclear_rd", 32'd0); check(ram_data_out);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
